// File: rtl/wl_row_sequencer.sv
// Row sequencer for the word-line decoder: round-robin command arbitration between
// host and scan requesters, then PRE / ACT / SENSE stepping per row with registered outputs.
module wl_row_sequencer #(
    parameter int NUM_ROWS = 162,
    parameter int PRE_CYC  = 2,
    parameter int ACT_CYC  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic [7:0] START0,
    input  logic [7:0] NROW0,
    input  logic       REQ1,
    input  logic [7:0] START1,
    input  logic [7:0] NROW1,
    output logic       GNT0,
    output logic       GNT1,
    input  logic       ABORT,
    output logic [7:0] ADD8,
    output logic       EN,
    output logic       STROBE,
    output logic       OWNER,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       ABORTED,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        ACT   = 2'd2,
        SENSE = 2'd3
    } state_t;

    localparam logic [7:0] PRE_LAST  = 8'(PRE_CYC - 1);
    localparam logic [7:0] ACT_LAST  = 8'(ACT_CYC - 1);
    localparam logic [7:0] ROW_LAST  = 8'(NUM_ROWS - 1);
    localparam logic [8:0] ROW_LIMIT = 9'(NUM_ROWS);

    state_t     state, state_nx;
    logic [7:0] cyc, cyc_nx;
    logic [7:0] rem, rem_nx;
    logic [7:0] add8_nx;
    logic       en_nx, strobe_nx, owner_nx, busy_nx, done_nx, err_nx, aborted_nx;
    logic       last_served, last_nx;
    logic       any_req, win, grant_ok, cmd_bad;
    logic [7:0] cmd_start, cmd_nrow;

    // Handshake: REQx is a level held by the requester until GNTx; START/NROW must be
    // stable while REQx is high and are captured on the clock edge that ends the GNTx cycle.
    // No grant is issued in the DONE cycle, so a new burst never overlaps completion.
    always_comb begin
        any_req   = REQ0 | REQ1;
        win       = (REQ0 && REQ1) ? ~last_served : REQ1;
        grant_ok  = (state == IDLE) && !DONE && !RST && any_req;
        GNT0      = grant_ok && !win;
        GNT1      = grant_ok && win;
        cmd_start = win ? START1 : START0;
        cmd_nrow  = win ? NROW1 : NROW0;
        cmd_bad   = (cmd_nrow == 8'd0) || ({1'b0, cmd_start} >= ROW_LIMIT);
    end

    always_comb begin
        state_nx   = state;
        cyc_nx     = cyc;
        rem_nx     = rem;
        add8_nx    = ADD8;
        owner_nx   = OWNER;
        busy_nx    = BUSY;
        last_nx    = last_served;
        en_nx      = 1'b0;
        strobe_nx  = 1'b0;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        aborted_nx = 1'b0;

        case (state)
            IDLE: begin
                if (grant_ok) begin
                    last_nx  = win;
                    owner_nx = win;
                    if (cmd_bad) begin
                        err_nx = 1'b1;
                    end else begin
                        add8_nx  = cmd_start;
                        rem_nx   = cmd_nrow;
                        cyc_nx   = 8'd0;
                        busy_nx  = 1'b1;
                        state_nx = PRE;
                    end
                end
            end
            PRE: begin
                if (cyc == PRE_LAST) begin
                    cyc_nx   = 8'd0;
                    en_nx    = 1'b1;
                    state_nx = ACT;
                end else begin
                    cyc_nx = cyc + 8'd1;
                end
            end
            ACT: begin
                en_nx = 1'b1;
                if (cyc == ACT_LAST) begin
                    cyc_nx    = 8'd0;
                    en_nx     = 1'b0;
                    strobe_nx = 1'b1;
                    state_nx  = SENSE;
                end else begin
                    cyc_nx = cyc + 8'd1;
                end
            end
            SENSE: begin
                rem_nx = rem - 8'd1;
                if (rem == 8'd1) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    add8_nx  = (ADD8 == ROW_LAST) ? 8'd0 : ADD8 + 8'd1;
                    state_nx = PRE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort wins over everything, including a final SENSE; the address is left alone.
        if (ABORT && (state != IDLE)) begin
            state_nx   = IDLE;
            add8_nx    = ADD8;
            en_nx      = 1'b0;
            strobe_nx  = 1'b0;
            busy_nx    = 1'b0;
            done_nx    = 1'b1;
            aborted_nx = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cyc         <= 8'd0;
            rem         <= 8'd0;
            ADD8        <= 8'd0;
            EN          <= 1'b0;
            STROBE      <= 1'b0;
            OWNER       <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
            ABORTED     <= 1'b0;
            last_served <= 1'b1;
        end else begin
            state       <= state_nx;
            cyc         <= cyc_nx;
            rem         <= rem_nx;
            ADD8        <= add8_nx;
            EN          <= en_nx;
            STROBE      <= strobe_nx;
            OWNER       <= owner_nx;
            BUSY        <= busy_nx;
            DONE        <= done_nx;
            ERR         <= err_nx;
            ABORTED     <= aborted_nx;
            last_served <= last_nx;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_wl_row_sequencer.sv
// Directed bench for wl_row_sequencer: bursts, round-robin ties, wrap, illegal commands,
// abort and mid-burst reset, with expected strobe rows held in a queue.
module tb_wl_row_sequencer;
    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, REQ1, ABORT;
    logic [7:0] START0, NROW0, START1, NROW1;
    logic       GNT0, GNT1, EN, STROBE, OWNER, BUSY, DONE, ERR, ABORTED;
    logic [7:0] ADD8;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] exp_q[$];

    wl_row_sequencer #(.NUM_ROWS(162), .PRE_CYC(2), .ACT_CYC(3)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .START0(START0), .NROW0(NROW0),
        .REQ1(REQ1), .START1(START1), .NROW1(NROW1),
        .GNT0(GNT0), .GNT1(GNT1), .ABORT(ABORT),
        .ADD8(ADD8), .EN(EN), .STROBE(STROBE), .OWNER(OWNER), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .ABORTED(ABORTED), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // checkers
    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drivers: inputs change 1 time unit after posedge, outputs are checked at negedge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_gnt(output logic g0, output logic g1, output int waited);
        g0 = 1'b0;
        g1 = 1'b0;
        waited = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (GNT0 || GNT1) begin
                g0 = GNT0;
                g1 = GNT1;
                break;
            end
            waited++;
            tick();
        end
    endtask

    // Follows a burst from the cycle after the grant; k counts cycles from BUSY rising.
    task automatic watch(input int abort_k, input logic exp_owner, output int done_k,
                         output int strobes, output int en_cyc, output int first_en,
                         output logic ab);
        int viol;
        logic [7:0] prev_add8;
        logic [7:0] e;
        done_k = 0; strobes = 0; en_cyc = 0; first_en = 0; ab = 1'b0; viol = 0;
        prev_add8 = ADD8;
        for (int k = 1; k <= 200; k++) begin
            ABORT = (k == abort_k);
            @(negedge CLK);
            if (k == 1) begin
                check_bit("busy_rise", BUSY, 1'b1);
                check_bit("owner", OWNER, exp_owner);
            end
            if ((ADD8 !== prev_add8) && EN) viol++;
            prev_add8 = ADD8;
            if (GNT0 || GNT1) viol++;
            if (EN) begin
                en_cyc++;
                if (first_en == 0) first_en = k;
            end
            if (STROBE) begin
                strobes++;
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = 8'hff;
                check_byte("strobe_row", ADD8, e);
            end
            if (DONE) begin
                done_k = k;
                ab = ABORTED;
                check_bit("done_busy", BUSY, 1'b0);
                check_bit("done_en", EN, 1'b0);
                check_bit("done_err", ERR, 1'b0);
                break;
            end
            tick();
        end
        ABORT = 1'b0;
        check_int("gnt_busy_or_addr_glitch", viol, 0);
        check_int("exp_q_drained", exp_q.size(), 0);
    endtask

    task automatic burst(input logic which, input logic [7:0] start, input logic [7:0] nrow,
                         input int abort_k, input int exp_done, input int exp_strobes,
                         input int exp_en, input logic exp_ab);
        logic g0, g1, ab;
        int waited, done_k, strobes, en_cyc, first_en;
        if (which) begin REQ1 = 1'b1; START1 = start; NROW1 = nrow; end
        else begin REQ0 = 1'b1; START0 = start; NROW0 = nrow; end
        wait_gnt(g0, g1, waited);
        check_int("gnt_wait", waited, 0);
        check_bit("gnt0", g0, !which);
        check_bit("gnt1", g1, which);
        tick();
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        watch(abort_k, which, done_k, strobes, en_cyc, first_en, ab);
        check_int("done_cycle", done_k, exp_done);
        check_int("strobe_count", strobes, exp_strobes);
        check_int("en_cycles", en_cyc, exp_en);
        check_int("first_en", first_en, 3);
        check_bit("aborted", ab, exp_ab);
        tick();
    endtask

    task automatic err_cmd(input logic [7:0] start, input logic [7:0] nrow);
        logic g0, g1;
        int waited;
        REQ0 = 1'b1; START0 = start; NROW0 = nrow;
        wait_gnt(g0, g1, waited);
        check_bit("err_gnt0", g0, 1'b1);
        tick();
        REQ0 = 1'b0;
        @(negedge CLK);
        check_bit("err_pulse", ERR, 1'b1);
        check_bit("err_busy", BUSY, 1'b0);
        check_bit("err_en", EN, 1'b0);
        check_bit("err_done", DONE, 1'b0);
        tick();
        @(negedge CLK);
        check_bit("err_one_cycle", ERR, 1'b0);
        check_bit("err_idle_busy", BUSY, 1'b0);
        tick();
    endtask

    // directed sequence
    initial begin
        logic g0, g1, ab;
        int waited, done_k, strobes, en_cyc, first_en, quiet;

        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; ABORT = 1'b0;
        START0 = 8'd0; NROW0 = 8'd0; START1 = 8'd0; NROW1 = 8'd0;
        repeat (3) tick();
        @(negedge CLK);
        check_byte("rst_add8", ADD8, 8'd0);
        check_bit("rst_en", EN, 1'b0);
        check_bit("rst_strobe", STROBE, 1'b0);
        check_bit("rst_owner", OWNER, 1'b0);
        check_bit("rst_busy", BUSY, 1'b0);
        check_bit("rst_done", DONE, 1'b0);
        check_bit("rst_err", ERR, 1'b0);
        check_bit("rst_aborted", ABORTED, 1'b0);
        tick();
        RST = 1'b0;

        // 3 rows from 5: 6 cycles/row, DONE 18 cycles after BUSY rises
        exp_q.push_back(8'd5); exp_q.push_back(8'd6); exp_q.push_back(8'd7);
        burst(1'b0, 8'd5, 8'd3, 0, 19, 3, 9, 1'b0);

        // Fresh reset so last-served is back to 1: ties go 0,1,0,1
        RST = 1'b1;
        tick();
        RST = 1'b0;
        REQ0 = 1'b1; START0 = 8'd20; NROW0 = 8'd1;
        REQ1 = 1'b1; START1 = 8'd100; NROW1 = 8'd1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back((i % 2 == 1) ? 8'd100 : 8'd20);
            wait_gnt(g0, g1, waited);
            check_bit("tie_gnt0", g0, (i % 2 == 0));
            check_bit("tie_gnt1", g1, (i % 2 == 1));
            tick();
            watch(0, (i % 2 == 1), done_k, strobes, en_cyc, first_en, ab);
            check_int("tie_done_cycle", done_k, 7);
            check_int("tie_strobes", strobes, 1);
            check_int("tie_en_cycles", en_cyc, 3);
            tick();
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;

        // Wrap past the last row
        exp_q.push_back(8'd160); exp_q.push_back(8'd161);
        exp_q.push_back(8'd0); exp_q.push_back(8'd1);
        burst(1'b1, 8'd160, 8'd4, 0, 25, 4, 12, 1'b0);

        // Last legal row alone
        exp_q.push_back(8'd161);
        burst(1'b0, 8'd161, 8'd1, 0, 7, 1, 3, 1'b0);

        // Illegal commands: zero rows, start out of range
        err_cmd(8'd5, 8'd0);
        err_cmd(8'd162, 8'd1);

        // ABORT while idle has no effect
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        @(negedge CLK);
        check_bit("idle_abort_done", DONE, 1'b0);
        check_bit("idle_abort_busy", BUSY, 1'b0);
        tick();

        // Abort during ACT of row 12 (cycles 15..17 of a burst from 10): no strobe for 12
        exp_q.push_back(8'd10); exp_q.push_back(8'd11);
        burst(1'b0, 8'd10, 8'd5, 15, 16, 2, 7, 1'b1);
        @(negedge CLK);
        check_byte("abort_add8_held", ADD8, 8'd12);
        tick();

        // Reset during ACT of row 50
        REQ0 = 1'b1; START0 = 8'd50; NROW0 = 8'd2;
        wait_gnt(g0, g1, waited);
        check_bit("rst_case_gnt0", g0, 1'b1);
        tick();
        REQ0 = 1'b0;
        repeat (2) tick();
        @(negedge CLK);
        check_bit("rst_case_act_en", EN, 1'b1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check_bit("midrst_en", EN, 1'b0);
        check_bit("midrst_busy", BUSY, 1'b0);
        check_byte("midrst_add8", ADD8, 8'd0);
        check_bit("midrst_owner", OWNER, 1'b0);
        check_bit("midrst_done", DONE, 1'b0);
        check_bit("midrst_strobe", STROBE, 1'b0);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge CLK);
            if (DONE || STROBE || EN || BUSY) quiet++;
        end
        check_int("midrst_no_activity", quiet, 0);
        tick();
        exp_q.push_back(8'd3);
        burst(1'b1, 8'd3, 8'd1, 0, 7, 1, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
